// File: rtl/resultinstrgen_pkg.sv
// Shared width helper and stage record for the ResultInstrGen multiplier pipeline.
package resultinstrgen_pkg;

  localparam int A_W_DEF   = 16;
  localparam int B_W_DEF   = 16;
  localparam int TAG_W_DEF = 4;
  localparam int FULL_W    = A_W_DEF + B_W_DEF;

  typedef struct packed {
    logic                 valid;
    logic                 sgn;
    logic [TAG_W_DEF-1:0] tag;
    logic [FULL_W-1:0]    data;
  } stage_t;

  function automatic int full_w(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

endpackage

// File: rtl/resultinstrgen_mul_core.sv
// Combinational signed/unsigned A_W x B_W multiply, truncated to P_W with overflow detect.
module resultinstrgen_mul_core
  import resultinstrgen_pkg::*;
#(
  parameter int A_W = 16,
  parameter int B_W = 16,
  parameter int P_W = 28
) (
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic           sgn,
  output logic [P_W-1:0] p,
  output logic           ovf
);

  localparam int FW = full_w(A_W, B_W);

  logic signed [FW-1:0] a_x;
  logic signed [FW-1:0] b_x;
  logic signed [FW-1:0] full;

  // Both operands extended to the full product width, so one signed multiply
  // yields the correct low FW bits in either mode.
  assign a_x  = {{B_W{sgn & a[A_W-1]}}, a};
  assign b_x  = {{A_W{sgn & b[B_W-1]}}, b};
  assign full = a_x * b_x;
  assign p    = full[P_W-1:0];

  generate
    if (P_W == FW) begin : g_no_ovf
      assign ovf = 1'b0;
    end else begin : g_ovf
      logic [FW-P_W-1:0] hi_u;
      logic [FW-P_W:0]   hi_s;
      assign hi_u = full[FW-1:P_W];
      assign hi_s = full[FW-1:P_W-1];
      assign ovf  = sgn ? !((&hi_s) || !(|hi_s)) : (|hi_u);
    end
  endgenerate

endmodule

// File: rtl/resultinstrgen_mul_pipe.sv
// Pipelined multiplier with valid/ready handshake, tag sideband and overflow flag.
module resultinstrgen_mul_pipe
  import resultinstrgen_pkg::*;
#(
  parameter int A_W       = 16,
  parameter int B_W       = 16,
  parameter int P_W       = 28,
  parameter int NUM_STAGE = 3,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [A_W-1:0]   in_a,
  input  logic [B_W-1:0]   in_b,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [P_W-1:0]   out_p,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  logic [P_W-1:0] core_p;
  logic           core_ovf;

  resultinstrgen_mul_core #(
    .A_W (A_W),
    .B_W (B_W),
    .P_W (P_W)
  ) u_core (
    .a   (in_a),
    .b   (in_b),
    .sgn (in_signed),
    .p   (core_p),
    .ovf (core_ovf)
  );

  logic             vld_p [NUM_STAGE];
  logic [P_W-1:0]   p_p   [NUM_STAGE];
  logic             ovf_p [NUM_STAGE];
  logic [TAG_W-1:0] tag_p [NUM_STAGE];
  logic             stall;

  assign stall    = vld_p[NUM_STAGE-1] && !out_ready;
  assign in_ready = !stall;

  // Stage 0 captures the product; later stages shift it toward the output in lockstep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_STAGE; i++) begin
        vld_p[i] <= 1'b0;
        p_p[i]   <= '0;
        ovf_p[i] <= 1'b0;
        tag_p[i] <= '0;
      end
    end else if (!stall) begin
      vld_p[0] <= in_valid;
      p_p[0]   <= core_p;
      ovf_p[0] <= core_ovf;
      tag_p[0] <= in_tag;
      for (int i = 1; i < NUM_STAGE; i++) begin
        vld_p[i] <= vld_p[i-1];
        p_p[i]   <= p_p[i-1];
        ovf_p[i] <= ovf_p[i-1];
        tag_p[i] <= tag_p[i-1];
      end
    end
  end

  assign out_valid = vld_p[NUM_STAGE-1];
  assign out_p     = p_p[NUM_STAGE-1];
  assign out_ovf   = ovf_p[NUM_STAGE-1];
  assign out_tag   = tag_p[NUM_STAGE-1];

endmodule

// File: tb/tb_resultinstrgen_mul_pipe.sv
// Directed bench for resultinstrgen_mul_pipe: arithmetic model scoreboard plus literal vectors.
module tb_resultinstrgen_mul_pipe;

  localparam int NS = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_signed = 1'b0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [27:0] out_p;
  logic        out_ovf;
  logic [3:0]  out_tag;

  always #5 clk = ~clk;

  resultinstrgen_mul_pipe #(
    .A_W       (16),
    .B_W       (16),
    .P_W       (28),
    .NUM_STAGE (NS),
    .TAG_W     (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_signed (in_signed),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_ovf   (out_ovf),
    .out_tag   (out_tag)
  );

  typedef struct {
    logic [27:0] p;
    logic        ovf;
    logic [3:0]  tag;
    int          acc_cyc;
    int          acc_stall;
  } exp_t;

  exp_t        exp_q[$];
  int          nchk = 0;
  int          nerr = 0;
  int          cyc = 0;
  int          stall_cnt = 0;
  int          rx_count = 0;
  int          first_rx = -1;
  int          last_rx = -1;
  bit          front_seen = 1'b0;
  bit          held = 1'b0;
  logic [27:0] held_p;
  logic        held_ovf;
  logic [3:0]  held_tag;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: expected results come from plain integer arithmetic on accepted beats.
  always @(negedge clk) begin
    longint av, bv, pr;
    exp_t   e;
    if (reset) begin
      exp_q.delete();
      front_seen = 1'b0;
      held = 1'b0;
      chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    end else begin
      chk("in_ready_rule", {63'd0, in_ready}, {63'd0, !(out_valid && !out_ready)});
      if (exp_q.size() == 0) begin
        chk("no_stale_result", {63'd0, out_valid}, 64'd0);
      end else if (out_valid) begin
        chk("out_p", {36'd0, out_p}, {36'd0, exp_q[0].p});
        chk("out_ovf", {63'd0, out_ovf}, {63'd0, exp_q[0].ovf});
        chk("out_tag", {60'd0, out_tag}, {60'd0, exp_q[0].tag});
        if (!front_seen) begin
          chk("latency", 64'(cyc - exp_q[0].acc_cyc - (stall_cnt - exp_q[0].acc_stall)), 64'(NS));
          front_seen = 1'b1;
          rx_count++;
          if (first_rx < 0) first_rx = cyc;
          last_rx = cyc;
        end
        if (held) begin
          chk("hold_p", {36'd0, out_p}, {36'd0, held_p});
          chk("hold_tag", {60'd0, out_tag}, {60'd0, held_tag});
          chk("hold_ovf", {63'd0, out_ovf}, {63'd0, held_ovf});
        end
      end
      held     = out_valid && !out_ready;
      held_p   = out_p;
      held_ovf = out_ovf;
      held_tag = out_tag;
      if (held) stall_cnt++;
      if (out_valid && out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        front_seen = 1'b0;
      end
      if (in_valid && in_ready) begin
        av = in_signed ? longint'($signed(in_a)) : longint'(in_a);
        bv = in_signed ? longint'($signed(in_b)) : longint'(in_b);
        pr = av * bv;
        e.p   = pr[27:0];
        e.ovf = in_signed ? (pr < -134217728 || pr >= 134217728) : (pr >= 268435456);
        e.tag = in_tag;
        e.acc_cyc = cyc;
        e.acc_stall = stall_cnt;
        exp_q.push_back(e);
      end
    end
  end

  task automatic send_lit(input logic [15:0] a, input logic [15:0] b, input logic s,
                          input logic [3:0] t, input logic [27:0] ep, input logic eo);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = a; in_b = b; in_signed = s; in_tag = t;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("lit_not_early", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lit_valid", {63'd0, out_valid}, 64'd1);
    chk("lit_p", {36'd0, out_p}, {36'd0, ep});
    chk("lit_ovf", {63'd0, out_ovf}, {63'd0, eo});
    chk("lit_tag", {60'd0, out_tag}, {60'd0, t});
  endtask

  initial begin
    int   i, k;
    logic fire;
    bit   pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_p", {36'd0, out_p}, 64'd0);
    chk("reset_out_ovf", {63'd0, out_ovf}, 64'd0);
    chk("reset_out_tag", {60'd0, out_tag}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

    send_lit(16'hFFFF, 16'hFFFF, 1'b0, 4'd5, 28'hFFE0001, 1'b1);
    send_lit(16'h0FFF, 16'h0FFF, 1'b0, 4'd1, 28'h0FFE001, 1'b0);
    send_lit(16'h0000, 16'h1234, 1'b0, 4'd2, 28'h0000000, 1'b0);
    send_lit(16'hFFFF, 16'h0002, 1'b1, 4'd3, 28'hFFFFFFE, 1'b0);
    send_lit(16'h8000, 16'h8000, 1'b1, 4'd4, 28'h0000000, 1'b1);
    send_lit(16'h8000, 16'h1000, 1'b1, 4'd6, 28'h8000000, 1'b0);
    send_lit(16'h8000, 16'hF000, 1'b1, 4'd7, 28'h8000000, 1'b1);
    send_lit(16'h4000, 16'h4000, 1'b0, 4'd8, 28'h0000000, 1'b1);
    send_lit(16'hFFFF, 16'hFFFF, 1'b1, 4'd9, 28'h0000001, 1'b0);

    // Backpressure: out_ready follows 1,0,0,1 while 8 beats stream in.
    @(posedge clk); #1;
    rx_count = 0;
    i = 0;
    k = 0;
    while ((i < 8 || exp_q.size() > 0) && k < 300) begin
      in_valid = (i < 8); in_a = 16'(i); in_b = 16'(i + 1); in_signed = 1'b0; in_tag = 4'(i);
      out_ready = pat[k % 4];
      @(negedge clk);
      fire = in_valid && in_ready;
      @(posedge clk); #1;
      if (fire) i++;
      k++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_finished_in_budget", {63'd0, k < 300}, 64'd1);
    chk("bp_rx_count", 64'(rx_count), 64'd8);

    // Full throughput: 100 back-to-back beats.
    rx_count = 0;
    first_rx = -1;
    for (int j = 0; j < 100; j++) begin
      in_valid = 1'b1;
      in_a = 16'(j * 797 + 3);
      in_b = 16'(j * 1237 + 11);
      in_signed = j[0];
      in_tag = 4'(j);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (NS + 1) @(posedge clk);
    #1;
    chk("tp_rx_count", 64'(rx_count), 64'd100);
    chk("tp_consecutive", 64'(last_rx - first_rx), 64'd99);
    repeat (3) begin
      @(negedge clk);
      chk("drain_idle", {63'd0, out_valid}, 64'd0);
    end

    // Reset with two beats in flight and the first one stalled at the output.
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 16'd7; in_b = 16'd9; in_signed = 1'b0; in_tag = 4'd1;
    @(posedge clk); #1;
    in_a = 16'd11; in_b = 16'd13; in_tag = 4'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    chk("inflight_valid", {63'd0, out_valid}, 64'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_valid", {63'd0, out_valid}, 64'd0);
    chk("async_reset_p", {36'd0, out_p}, 64'd0);
    chk("async_reset_tag", {60'd0, out_tag}, 64'd0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    send_lit(16'd100, 16'd200, 1'b0, 4'd12, 28'd20000, 1'b0);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
